// File: rtl/display_pkg.sv
// Shared constants and types for the display arbiter slice.
package display_pkg;

   localparam int unsigned NSRC  = 4;
   localparam logic [6:0]  BLANK = 7'h7F;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/display_word.sv
// Hex decoder: four nibbles of a 16-bit word to active-low 7-segment patterns.
module display_word (
   input  logic [15:0] word,
   output logic [6:0]  h0,
   output logic [6:0]  h1,
   output logic [6:0]  h2,
   output logic [6:0]  h3
);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Decode each nibble independently; h0 is the least significant nibble.
   always_comb begin
      h0 = hex7(word[3:0]);
      h1 = hex7(word[7:4]);
      h2 = hex7(word[11:8]);
      h3 = hex7(word[15:12]);
   end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter that grants one of four sources the 4-digit hex display
// for DWELL cycles at a time, with a hold input that freezes rotation.
module display_arbiter
   import display_pkg::*;
#(
   parameter int unsigned DWELL = 25000000,
   parameter int unsigned CW    = 25
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] req,
   input  logic [15:0]     word0,
   input  logic [15:0]     word1,
   input  logic [15:0]     word2,
   input  logic [15:0]     word3,
   input  logic            hold,
   output logic [NSRC-1:0] grant,
   output logic [1:0]      src,
   output logic [6:0]      h0,
   output logic [6:0]      h1,
   output logic [6:0]      h2,
   output logic [6:0]      h3
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   state_t        state, state_n;
   logic [1:0]    src_n;
   logic [1:0]    last_src;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   word_q, word_sel;
   logic [6:0]    d0, d1, d2, d3;

   // First set request bit at or above start, wrapping; the caller passes
   // owner+1 so the current owner is considered last.
   function automatic logic [1:0] rr_pick(input logic [NSRC-1:0] r,
                                          input logic [1:0]      start);
      logic [1:0] idx;
      logic       found;
      logic [1:0] pick;
      pick  = start;
      found = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         idx = start + 2'(i);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Next-state, next-owner and dwell counter.
   always_comb begin
      state_n = state;
      src_n   = src;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = SHOW;
               src_n   = rr_pick(req, last_src + 2'd1);
               cnt_n   = '0;
            end
         end
         SHOW: begin
            if (req == '0) begin
               state_n = IDLE;
               src_n   = 2'd0;
               cnt_n   = '0;
            end else if (!req[src] || (!hold && cnt == CNT_LAST)) begin
               // A dropped owner forces rotation even while held.
               src_n = rr_pick(req, src + 2'd1);
               cnt_n = '0;
            end else if (!hold) begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            src_n   = 2'd0;
            cnt_n   = '0;
         end
      endcase
   end

   // Source word for the owner being granted at this edge.
   always_comb begin
      case (src_n)
         2'd0:    word_sel = word0;
         2'd1:    word_sel = word1;
         2'd2:    word_sel = word2;
         default: word_sel = word3;
      endcase
   end

   // State, ownership, counter and display register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         src      <= 2'd0;
         grant    <= '0;
         last_src <= 2'd3;
         cnt      <= '0;
         word_q   <= '0;
      end else begin
         state <= state_n;
         src   <= src_n;
         cnt   <= cnt_n;
         if (state_n == SHOW) begin
            grant    <= NSRC'(1) << src_n;
            last_src <= src_n;
            word_q   <= word_sel;
         end else begin
            grant <= '0;
         end
      end
   end

   display_word u_dec (
      .word (word_q),
      .h0   (d0),
      .h1   (d1),
      .h2   (d2),
      .h3   (d3)
   );

   // Blank the digits whenever no source owns the display.
   always_comb begin
      if (state == SHOW) begin
         h0 = d0;
         h1 = d1;
         h2 = d2;
         h3 = d3;
      end else begin
         h0 = BLANK;
         h1 = BLANK;
         h2 = BLANK;
         h3 = BLANK;
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with DWELL=4: a reference model pushes expected
// outputs per edge into a scoreboard, plus fixed-value checks of key scenarios.
module tb_display_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] word0, word1, word2, word3;
   logic        hold;
   logic [3:0]  grant;
   logic [1:0]  src;
   logic [6:0]  h0, h1, h2, h3;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [3:0]  g;
      logic [1:0]  s;
      logic [27:0] h;
   } exp_t;
   exp_t sb[$];

   // reference model state
   logic        m_show;
   logic [1:0]  m_src;
   logic [1:0]  m_last;
   int unsigned m_cnt;
   logic [15:0] m_wq;

   localparam logic [27:0] ALL_BLANK = {4{7'h7F}};

   display_arbiter #(.DWELL(4), .CW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .word0 (word0),
      .word1 (word1),
      .word2 (word2),
      .word3 (word3),
      .hold  (hold),
      .grant (grant),
      .src   (src),
      .h0    (h0),
      .h1    (h1),
      .h2    (h2),
      .h3    (h3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic logic [27:0] digits(input logic [15:0] w);
      return {seg(w[15:12]), seg(w[11:8]), seg(w[7:4]), seg(w[3:0])};
   endfunction

   function automatic logic [1:0] mpick(input logic [3:0] r, input logic [1:0] after);
      int unsigned c;
      for (int unsigned k = 1; k <= 4; k++) begin
         c = (int'(after) + k) % 4;
         if (r[c]) return 2'(c);
      end
      return after;
   endfunction

   function automatic logic [15:0] wsel(input logic [1:0] s);
      case (s)
         2'd0:    return word0;
         2'd1:    return word1;
         2'd2:    return word2;
         default: return word3;
      endcase
   endfunction

   task automatic model_reset;
      m_show = 1'b0;
      m_src  = 2'd0;
      m_last = 2'd3;
      m_cnt  = 0;
      m_wq   = '0;
   endtask

   task automatic model_edge;
      if (!m_show) begin
         if (req != 4'b0) begin
            m_show = 1'b1;
            m_src  = mpick(req, m_last);
            m_cnt  = 0;
            m_last = m_src;
            m_wq   = wsel(m_src);
         end
      end else if (req == 4'b0) begin
         m_show = 1'b0;
         m_src  = 2'd0;
         m_cnt  = 0;
      end else begin
         if (!req[m_src] || (!hold && m_cnt == 3)) begin
            m_src = mpick(req, m_src);
            m_cnt = 0;
         end else if (!hold) begin
            m_cnt++;
         end
         m_last = m_src;
         m_wq   = wsel(m_src);
      end
   endtask

   // One clock: predict, push, advance, pop and compare.
   task automatic step;
      exp_t e;
      model_edge();
      e.g = m_show ? (4'b0001 << m_src) : 4'b0000;
      e.s = m_src;
      e.h = m_show ? digits(m_wq) : ALL_BLANK;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_grant", 32'(grant), 32'(e.g));
      chk("sb_src", 32'(src), 32'(e.s));
      chk("sb_h", 32'({h3, h2, h1, h0}), 32'(e.h));
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset pulse placed mid-cycle, then released away from edges.
   task automatic pulse_reset;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_src", 32'(src), 32'h0);
      chk("rst_h", 32'({h3, h2, h1, h0}), 32'(ALL_BLANK));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0;
      hold  = 1'b0;
      word0 = 16'h0;
      word1 = 16'h5678;
      word2 = 16'h9ABC;
      word3 = 16'hDEF0;
      model_reset();
      #1;
      chk("init_grant", 32'(grant), 32'h0);
      chk("init_h", 32'({h3, h2, h1, h0}), 32'(ALL_BLANK));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single requester, dwell wraps without changing owner
      word0 = 16'h1234;
      req   = 4'b0001;
      step();
      chk("first_grant", 32'(grant), 32'h1);
      chk("first_digits", 32'({h3, h2, h1, h0}), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
      step();
      chk("digits_hold", 32'({h3, h2, h1, h0}), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
      steps(8);
      chk("self_regrant", 32'(grant), 32'h1);

      // round robin over 1011 from a fresh reset
      pulse_reset();
      req = 4'b1011;
      for (int unsigned k = 1; k <= 13; k++) begin
         step();
         if (k <= 4)       chk("rr_seq", 32'(grant), 32'h1);
         else if (k <= 8)  chk("rr_seq", 32'(grant), 32'h2);
         else if (k <= 12) chk("rr_seq", 32'(grant), 32'h8);
         else              chk("rr_seq", 32'(grant), 32'h1);
      end

      // owner 1 drops its request at cnt=1
      steps(5);
      chk("own1", 32'(grant), 32'h2);
      req = 4'b1001;
      step();
      chk("drop_rotate", 32'(grant), 32'h8);
      req = 4'b0000;
      step();
      chk("to_idle_grant", 32'(grant), 32'h0);
      chk("to_idle_h", 32'({h3, h2, h1, h0}), 32'(ALL_BLANK));

      // hold freezes rotation, then the remaining count elapses
      req = 4'b0011;
      steps(2);
      chk("hold_owner", 32'(grant), 32'h1);
      hold = 1'b1;
      for (int unsigned k = 0; k < 10; k++) begin
         step();
         chk("hold_frozen", 32'(grant), 32'h1);
      end
      hold = 1'b0;
      steps(2);
      chk("hold_release_a", 32'(grant), 32'h1);
      step();
      chk("hold_release_b", 32'(grant), 32'h2);

      // live word update for owner 0
      req   = 4'b0001;
      word0 = 16'hABCD;
      steps(2);
      chk("word_abcd", 32'({h3, h2, h1, h0}), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
      word0 = 16'hEF01;
      step();
      chk("word_ef01", 32'({h3, h2, h1, h0}), 32'({7'h06, 7'h0E, 7'h40, 7'h79}));

      // reset mid-dwell, then all sources request
      req = 4'b1111;
      step();
      pulse_reset();
      chk("post_rst_idle", 32'(grant), 32'h0);
      step();
      chk("post_rst_src0", 32'(grant), 32'h1);

      // random traffic against the model
      for (int unsigned k = 0; k < 80; k++) begin
         req   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) req = 4'b0;
         hold  = ($urandom_range(0, 3) == 0);
         word1 = 16'($urandom);
         word2 = 16'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low; the ports SHALL be named clk and rst_n.
REQ-002 Parameter DWELL, default 25000000, SHALL set the display cycles per granted source (0.5 s at 50 MHz); legal range 2..2^25-1.
REQ-003 Parameter CW, default 25, SHALL set the dwell counter width, with 2^CW > DWELL.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-source display request; bit i belongs to source i.
REQ-007 word0..word3  input  16 each  source values to display.
REQ-008 hold  input  1  freezes rotation while high.
REQ-009 grant  output  4  one-hot current owner; all zero when idle.
REQ-010 src  output  2  index of the current owner; 0 when idle.
REQ-011 h0..h3  output  7 each  active-low segment patterns; h0 is the least significant nibble.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and SHOW (one owner).
REQ-013 IDLE->SHOW SHALL occur on the first edge where req!=0; the owner is the first set req bit searching upward, with wrap, from last_src+1.
REQ-014 In SHOW, dwell counter cnt SHALL increment each cycle while hold=0, and SHALL hold its value while hold=1.
REQ-015 Rotation SHALL occur at the edge where cnt==DWELL-1 and hold=0: the new owner is the next set req bit after src, with wrap; cnt SHALL become 0.
REQ-016 With only the current owner requesting at rotation, the owner SHALL re-grant itself and cnt SHALL become 0.
REQ-017 If req[src] drops in SHOW, the block SHALL rotate on the next edge regardless of cnt or hold, or go to IDLE if req==0.
REQ-018 SHOW->IDLE SHALL occur on the edge after req becomes 0; last_src SHALL retain the last owner.
REQ-019 Rotation order SHALL be round-robin: no requester waits more than 3 dwell periods while continuously requesting, with hold=0.
REQ-020 Display register word_q SHALL load word[next_src] at every edge in SHOW, including the granting edge, so the digits reflect source data with one cycle of latency.
REQ-021 In IDLE, all h outputs SHALL be BLANK (7'h7F, all segments off).
REQ-022 In SHOW, h3..h0 SHALL show the hex digits of word_q[15:12]..word_q[3:0] using the standard active-low encoding (0->7'h40, 8->7'h00, F->7'h0E).
REQ-023 grant, src and the state SHALL be registered, and grant SHALL always equal 1<<src in SHOW.

Reset
REQ-024 On rst_n low, the block SHALL immediately set state=IDLE, grant=0, src=0, last_src=3, cnt=0, word_q=0 and h0..h3=BLANK.
REQ-025 A reset asserted mid-dwell SHALL abandon the current owner; after release, arbitration SHALL restart from source 0.

Structure
REQ-026 Shared package display_pkg SHALL hold BLANK, the state encodings IDLE/SHOW, and the source-count constant NSRC=4.
REQ-027 The hex decode SHALL use one sub-module, the team's existing display_word decoder, instantiated once on word_q, with outputs muxed to BLANK in IDLE.
REQ-028 The round-robin next-owner search SHALL be a combinational function local to the block.

Verification (DWELL=4)
REQ-029 Reset, then req=0001, word0=16'h1234 -> grant=0001 after 1 edge; h3..h0 show 1,2,3,4 one cycle later; cnt wraps every 4 cycles with the grant unchanged.
REQ-030 req=1011 held -> grant sequence 0001,0010,1000,0001, each held exactly 4 cycles.
REQ-031 Owner 1, req[1] drops at cnt=1 -> the next edge grants source 3 with cnt=0; drop all req -> IDLE and h0..h3=7'h7F the next edge.
REQ-032 hold=1 for 10 cycles in SHOW with req=0011 -> grant is frozen; release -> rotation occurs after the remaining count.
REQ-033 rst_n pulsed low mid-dwell, asynchronous to clk -> outputs reach their reset values before the next edge; after release, req=1111 grants source 0.
REQ-034 Owner 0, word0 changes 16'hABCD->16'hEF01 mid-dwell -> the digits update one cycle later to E,F,0,1.
